// File: rtl/incdec_rr_arbiter.sv
// Round-robin front end for a shared inc/pass/dec unit. It grants one requester
// per cycle and returns a registered result tagged with the requester index.
module incdec_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_number,
  input  logic [NUM_REQ*2-1:0]     req_select,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [NUM_REQ-1:0][WIDTH-1:0] num;
  logic [NUM_REQ-1:0][1:0]       sel;
  logic [0:0]                    state_q, state_d;
  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic [ID_W-1:0]               id_q, id_d;
  logic [WIDTH-1:0]              res_q, res_d;
  logic [ID_W-1:0]               gnt_idx, cand;
  logic                          gnt_found, can_accept, accept;
  logic [WIDTH-1:0]              op_res;

  assign num = req_number;
  assign sel = req_select;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign can_accept = (state_q == IDLE) || rsp_ready;
  assign accept     = gnt_found && can_accept && rst_n;
  assign req_ready  = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

  // res_q doubles as last_result: both load the same value on every accept.
  always_comb begin
    case (sel[gnt_idx])
      2'b00:   op_res = num[gnt_idx] + WIDTH'(1);
      2'b01:   op_res = num[gnt_idx];
      2'b10:   op_res = num[gnt_idx] - WIDTH'(1);
      default: op_res = res_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    res_d   = res_q;
    if (accept) begin
      state_d = RESP;
      id_d    = gnt_idx;
      res_d   = op_res;
      ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      res_q   <= res_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
endmodule

// File: tb/tb_incdec_rr_arbiter.sv
// Bench for incdec_rr_arbiter: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of grant/result rules.
module tb_incdec_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_number;
  logic [N*2-1:0]  req_select;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_result;

  incdec_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_number(req_number),
    .req_select(req_select), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: pending response, its id/result, last result, rotating pointer.
  bit m_valid;
  int m_id, m_res, m_last, m_ptr;
  int last_g = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_res = 0; m_last = 0; m_ptr = 0; last_g = -1;
  endtask

  function automatic int model_grant();
    if (!rst_n) return -1;
    if (m_valid && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic int model_op(input int n, input int s);
    case (s)
      0:       return (n + 1) % 256;
      1:       return n;
      2:       return (n + 255) % 256;
      default: return m_last;
    endcase
  endfunction

  // Called at posedge+1: check on the falling edge, then advance the model.
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = model_grant();
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_id", 32'(rsp_id), m_id);
      chk("rsp_result", 32'(rsp_result), m_res);
    end
    @(posedge clk);
    last_g = g;
    if (g >= 0) begin
      m_res   = model_op(int'(req_number[g*W +: W]), int'(req_select[g*2 +: 2]));
      m_last  = m_res;
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] n, input logic [1:0] s);
    req_valid[i]          = v;
    req_number[i*W +: W]  = n;
    req_select[i*2 +: 2]  = s;
  endtask

  task automatic single(input int i, input logic [W-1:0] n, input logic [1:0] s,
                        input logic [W-1:0] exp, input string name);
    req_valid = '0;
    set_req(i, 1'b1, n, s);
    step();
    req_valid = '0;
    chk(name, 32'(rsp_result), 32'(exp));
    chk({name, "_id"}, 32'(rsp_id), i);
    step();
  endtask

  initial begin
    logic [IW-1:0] sid;
    logic [W-1:0]  sres;
    int prev;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_number = '0; req_select = '0;
    model_reset();
    #2;
    req_valid = 4'b0001;
    #10;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_rsp_result", 32'(rsp_result), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed ops with hand-computed results.
    single(1, 8'hAA, 2'b11, 8'h00, "hold_after_reset");
    single(0, 8'h41, 2'b00, 8'h42, "inc_41");
    single(2, 8'hFF, 2'b00, 8'h00, "inc_wrap");
    single(3, 8'h00, 2'b10, 8'hFF, "dec_wrap");
    single(1, 8'h5A, 2'b01, 8'h5A, "pass_5a");
    single(0, 8'h10, 2'b10, 8'h0F, "dec_10");
    single(2, 8'hAA, 2'b11, 8'h0F, "hold_0f");

    // Round-robin with all requesters valid: ids step by one every cycle.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, W'($urandom), 2'($urandom));
    step();
    prev = int'(rsp_id);
    for (int c = 0; c < 8; c++) begin
      set_req(prev, 1'b1, W'($urandom), 2'($urandom));
      step();
      chk("rr_seq", 32'(rsp_id), (prev + 1) % N);
      chk("rr_valid", 32'(rsp_valid), 1);
      prev = int'(rsp_id);
    end
    req_valid = '0;
    step();

    // Backpressure: response held, no grants, then immediate accept on release.
    set_req(1, 1'b1, 8'h20, 2'b00);
    step();
    sid = rsp_id; sres = rsp_result;
    chk("bp_first", 32'(sres), 32'h21);
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'h30 + W'(i), 2'b01);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_id_stable", 32'(rsp_id), 32'(sid));
      chk("bp_res_stable", 32'(rsp_result), 32'(sres));
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_id", 32'(rsp_id), 2);
    chk("bp_release_res", 32'(rsp_result), 32'h32);
    req_valid = '0;
    step();

    // Random traffic; pending requests stay stable unless dropped.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && i != last_g && ($urandom % 8) != 0))
          set_req(i, 1'($urandom % 2), W'($urandom), 2'($urandom));
      end
      rsp_ready = (($urandom % 4) != 0);
      step();
    end

    // Async reset mid-stream with a response pending.
    req_valid = 4'b1111; rsp_ready = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 0);
    chk("async_req_ready", 32'(req_ready), 0);
    model_reset();
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    set_req(2, 1'b1, 8'h07, 2'b00);
    set_req(0, 1'b1, 8'h09, 2'b10);
    step();
    chk("post_reset_first", 32'(rsp_id), 0);
    chk("post_reset_res", 32'(rsp_result), 32'h08);
    req_valid[0] = 1'b0;
    step();
    chk("post_reset_second", 32'(rsp_id), 2);
    req_valid = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/incdec_rr_arbiter.md
# incdec_rr_arbiter

Shares one 8-bit increment/pass/decrement unit among several requesters. Each requester presents an operand and a 2-bit operation under a valid/ready handshake. A round-robin arbiter grants one request per cycle. The block returns a registered result, tagged with the requester index, on a single response channel. It sits between the requesting agents and the combinational inc/pass/dec datapath and is the only driver of that datapath's operand and select inputs.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 8: operand/result width.
- ID_W, default 2: width of the requester index; must equal ceil(log2(NUM_REQ)).

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_number  input  NUM_REQ*WIDTH  operands; requester i occupies bits [i*WIDTH +: WIDTH]
- req_select  input  NUM_REQ*2  operations; requester i occupies bits [i*2 +: 2]
- req_ready  output  NUM_REQ  one-hot grant, or all zero
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_id  output  ID_W  index of the granted requester
- rsp_result  output  WIDTH  operation result

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Operation encoding:
  - 2'b00: number + 1, modulo 2^WIDTH.
  - 2'b01: number.
  - 2'b10: number − 1, modulo 2^WIDTH.
  - 2'b11: hold, returns last_result and ignores number.
- last_result:
  - Internal register, reset to 0.
  - Loaded with the computed result on every accepted request. A hold request reloads the same value.
  - Wrap cases: 8'hFF + 1 gives 8'h00; 8'h00 − 1 gives 8'hFF. No carry or borrow output.
- FSM states:
  - IDLE: rsp_valid=0.
  - RESP: rsp_valid=1.
- can_accept = (state==IDLE) || rsp_ready.
- Arbitration:
  - Round-robin pointer ptr (ID_W bits, reset 0).
  - Among requesters with req_valid=1, grant the first at or after ptr, wrapping modulo NUM_REQ.
  - req_ready[g]=1 for the granted index g only when can_accept.
  - req_ready is combinational from req_valid, state, ptr and rsp_ready.
- Accept (req_valid[g] && req_ready[g]):
  - Compute on req_number[g] and req_select[g].
  - Register the result into rsp_result and last_result, and g into rsp_id.
  - Next state is RESP; ptr becomes (g+1) mod NUM_REQ.
- Transitions:
  - IDLE to RESP on accept.
  - RESP to RESP on rsp_ready with a new accept.
  - RESP to IDLE on rsp_ready with no request.
  - RESP to RESP, with outputs unchanged, while rsp_ready=0.
- Response stability: while rsp_valid=1 and rsp_ready=0, rsp_id and rsp_result hold stable and req_ready is all zero.
- Requester rules:
  - A requester must hold req_number and req_select stable while req_valid=1 and not accepted.
  - Deasserting req_valid before acceptance is allowed; the block ignores it.
- Priority: ptr advances only on accept. An unserved requester waits at most NUM_REQ−1 accepts.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, rsp_result=0.
  - req_ready all zero while rst_n=0.
  - state=IDLE, ptr=0, last_result=0.
- Latency: request accepted at edge N gives rsp_valid=1 with its result in the cycle after edge N.
- Throughput: one operation per cycle while rsp_ready stays 1.
- Simultaneous events:
  - Response handshake and new accept in the same cycle: the new response replaces the old at that edge, with no bubble.
  - Hold request accepted back-to-back after an op returns that op's result; last_result updates at the same edge as the response register.
- Reset mid-operation: a pending response is discarded and ptr returns to 0. No response is produced for a request that was not accepted before reset.
- Outputs rsp_* are registered; no combinational path from req_* to rsp_*.

## Test plan
- Reset / single op: after reset, req_valid=4'b0001, number 8'h41, select 00 → req_ready[0]=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=8'h42.
- Wrap: select 00 with 8'hFF → 8'h00; select 10 with 8'h00 → 8'hFF; select 01 with 8'h5A → 8'h5A.
- Hold: decrement of 8'h10 (→ 8'h0F), then select 11 with number 8'hAA → 8'h0F; hold immediately after reset → 8'h00.
- Round-robin: all four valid continuously with rsp_ready=1 → grants 0,1,2,3,0,… on consecutive cycles, rsp_id sequence matching, one response per cycle.
- Backpressure: rsp_ready=0 for 5 cycles while pending → rsp_id and rsp_result stable, req_ready=0. On rsp_ready=1, the next request is accepted the same cycle with no bubble.
- Async reset: assert rst_n=0 mid-stream between edges → rsp_valid drops immediately. After release with requester 2 and requester 0 valid, requester 0 is granted first (ptr=0).
